// File: rtl/mdio_slave_if.sv
// Pad-side MDIO signals and host register-file strobe bus for mdio_slave.
`timescale 1ns/1ps
interface mdio_slave_if;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        reg_we;
  logic [15:0] reg_wdata;
  logic        frame_err;
  logic        busy;

  modport slave (
    input  mdc, mdio_in, reg_rdata,
    output mdio_out, mdio_oe, reg_addr, reg_rd, reg_we, reg_wdata, frame_err, busy
  );

  modport master (
    output mdc, mdio_in, reg_rdata,
    input  mdio_out, mdio_oe, reg_addr, reg_rd, reg_we, reg_wdata, frame_err, busy
  );
endinterface

// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: oversamples mdc/mdio on clk, decodes frames and
// serves register reads/writes through a one-cycle strobe interface.
`timescale 1ns/1ps
module mdio_slave #(
  parameter logic [4:0]  PHY_ADDR     = 5'h01,
  parameter int unsigned MIN_PREAMBLE = 32
) (
  input  logic        clk,
  input  logic        rst,
  mdio_slave_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
  } state_t;

  localparam logic [5:0] MIN_PRE = 6'(MIN_PREAMBLE);

  logic mdc_s1, mdc_s2, mdc_s3, mdio_s1, mdio_s2;
  logic mdc_rise, bit_in;

  state_t      state, state_nx;
  logic [4:0]  bit_cnt, bit_cnt_nx;
  logic [5:0]  pre_cnt, pre_cnt_nx;
  logic        is_read, is_read_nx;
  logic        foreign, foreign_nx;
  logic [14:0] in_sh, in_sh_nx;
  logic [15:0] out_sh, out_sh_nx;
  logic [15:0] in_word;

  logic        mdio_out_q, mdio_out_nx;
  logic        mdio_oe_q, mdio_oe_nx;
  logic [4:0]  reg_addr_q, reg_addr_nx;
  logic        reg_rd_q, reg_rd_nx;
  logic        reg_we_q, reg_we_nx;
  logic [15:0] reg_wdata_q, reg_wdata_nx;
  logic        frame_err_q, frame_err_nx;
  logic        busy_q, busy_nx;

  assign mdc_rise = mdc_s2 & ~mdc_s3;
  assign bit_in   = mdio_s2;
  assign in_word  = {in_sh, bit_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_s1  <= 1'b1;
      mdc_s2  <= 1'b1;
      mdc_s3  <= 1'b1;
      mdio_s1 <= 1'b1;
      mdio_s2 <= 1'b1;
    end else begin
      mdc_s1  <= bus.mdc;
      mdc_s2  <= mdc_s1;
      mdc_s3  <= mdc_s2;
      mdio_s1 <= bus.mdio_in;
      mdio_s2 <= mdio_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      pre_cnt     <= '0;
      is_read     <= 1'b0;
      foreign     <= 1'b0;
      in_sh       <= '0;
      out_sh      <= '0;
      mdio_out_q  <= 1'b0;
      mdio_oe_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_rd_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_wdata_q <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      pre_cnt     <= pre_cnt_nx;
      is_read     <= is_read_nx;
      foreign     <= foreign_nx;
      in_sh       <= in_sh_nx;
      out_sh      <= out_sh_nx;
      mdio_out_q  <= mdio_out_nx;
      mdio_oe_q   <= mdio_oe_nx;
      reg_addr_q  <= reg_addr_nx;
      reg_rd_q    <= reg_rd_nx;
      reg_we_q    <= reg_we_nx;
      reg_wdata_q <= reg_wdata_nx;
      frame_err_q <= frame_err_nx;
      busy_q      <= busy_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    pre_cnt_nx   = pre_cnt;
    is_read_nx   = is_read;
    foreign_nx   = foreign;
    in_sh_nx     = in_sh;
    out_sh_nx    = out_sh;
    mdio_out_nx  = mdio_out_q;
    mdio_oe_nx   = mdio_oe_q;
    reg_addr_nx  = reg_addr_q;
    reg_rd_nx    = 1'b0;
    reg_we_nx    = 1'b0;
    reg_wdata_nx = reg_wdata_q;
    frame_err_nx = 1'b0;
    busy_nx      = busy_q;

    if (mdc_rise) begin
      in_sh_nx   = in_word[14:0];
      bit_cnt_nx = bit_cnt + 5'd1;
      case (state)
        S_IDLE: begin
          if (bit_in) begin
            if (pre_cnt != '1) pre_cnt_nx = pre_cnt + 6'd1;
          end else begin
            pre_cnt_nx = '0;
            if (pre_cnt >= MIN_PRE) state_nx = S_ST;
          end
        end
        S_ST: begin
          if (bit_in) begin
            state_nx = S_OP;
            busy_nx  = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
        S_OP: begin
          if (bit_cnt == 5'd1) begin
            case (in_word[1:0])
              2'b10: begin is_read_nx = 1'b1; state_nx = S_PHYAD; end
              2'b01: begin is_read_nx = 1'b0; state_nx = S_PHYAD; end
              default: begin frame_err_nx = 1'b1; state_nx = S_SKIP; end
            endcase
          end
        end
        S_PHYAD: begin
          if (bit_cnt == 5'd4) begin
            foreign_nx = (in_word[4:0] != PHY_ADDR);
            state_nx   = S_REGAD;
          end
        end
        S_REGAD: begin
          if (bit_cnt == 5'd4) begin
            if (foreign) begin
              state_nx = S_SKIP;
            end else begin
              reg_addr_nx = in_word[4:0];
              reg_rd_nx   = is_read;
              state_nx    = S_TA;
            end
          end
        end
        S_TA: begin
          if (bit_cnt == 5'd0 && is_read) begin
            out_sh_nx   = bus.reg_rdata;
            mdio_oe_nx  = 1'b1;
            mdio_out_nx = 1'b0;
          end
          if (bit_cnt == 5'd1) begin
            // Second TA edge already presents data[15], so RDATA sees 15 more bits.
            if (is_read) begin
              mdio_out_nx = out_sh[15];
              out_sh_nx   = {out_sh[14:0], 1'b0};
              state_nx    = S_RDATA;
            end else begin
              state_nx = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (bit_cnt == 5'd15) begin
            reg_we_nx    = 1'b1;
            reg_wdata_nx = in_word;
            state_nx     = S_IDLE;
          end
        end
        S_RDATA: begin
          if (bit_cnt == 5'd15) begin
            mdio_oe_nx  = 1'b0;
            mdio_out_nx = 1'b0;
            state_nx    = S_IDLE;
          end else begin
            mdio_out_nx = out_sh[15];
            out_sh_nx   = {out_sh[14:0], 1'b0};
          end
        end
        S_SKIP: begin
          if (bit_cnt == 5'd17) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase

      if (state_nx != state) bit_cnt_nx = '0;
      if (state_nx == S_IDLE && state != S_IDLE) begin
        busy_nx    = 1'b0;
        pre_cnt_nx = '0;
      end
    end
  end

  assign bus.mdio_out  = mdio_out_q;
  assign bus.mdio_oe   = mdio_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mdio_slave.sv
// Bench for mdio_slave: plays an MDIO master bit by bit and checks each frame
// against frame-level expectations derived from preamble, opcode and address.
`timescale 1ns/1ps
module tb_mdio_slave;
  localparam int         MINP   = 32;
  localparam logic [4:0] MY_PHY = 5'h01;
  localparam int         MDC_CLKS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_oe = 1'b0;
  logic m_val = 1'b1;
  logic [15:0] host_mem [32];

  mdio_slave_if bus();

  mdio_slave #(.PHY_ADDR(MY_PHY), .MIN_PREAMBLE(MINP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Open-drain line with pull-up: slave wins when enabled, else master, else 1.
  assign bus.mdio_in   = bus.mdio_oe ? bus.mdio_out : (m_oe ? m_val : 1'b1);
  assign bus.reg_rdata = host_mem[bus.reg_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt = 0, we_cnt = 0, err_cnt = 0, oe_clks = 0;
  logic [4:0]  rd_addr, we_addr;
  logic [15:0] we_data;

  always @(negedge clk) begin
    if (bus.reg_rd) begin rd_cnt++; rd_addr = bus.reg_addr; end
    if (bus.reg_we) begin we_cnt++; we_addr = bus.reg_addr; we_data = bus.reg_wdata; end
    if (bus.frame_err) err_cnt++;
    if (bus.mdio_oe) oe_clks++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mdc_bit(input logic drive, input logic val, output logic smp);
    m_oe    = drive;
    m_val   = val;
    bus.mdc = 1'b0;
    repeat (MDC_CLKS / 2) @(negedge clk);
    bus.mdc = 1'b1;
    smp     = bus.mdio_in;
    repeat (MDC_CLKS / 2) @(negedge clk);
  endtask

  task automatic do_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] wd, input int abort_bit);
    logic [31:0] fb;
    logic [15:0] rdat;
    logic        smp, ta_s, reading, accepted, own, valid, exp_rd, exp_we, exp_err;
    int          rd0, we0, err0, oe0, busy_bits, exp_busy;
    fb       = {2'b01, op, phy, ra, 2'b10, wd};
    reading  = (op == 2'b10);
    accepted = (npre >= MINP);
    own      = (phy == MY_PHY);
    valid    = (op == 2'b10) || (op == 2'b01);
    exp_rd   = accepted && own && op == 2'b10;
    exp_we   = accepted && own && op == 2'b01;
    exp_err  = accepted && !valid;
    exp_busy = !accepted ? 0 : (!valid ? 20 : 30);
    rd0 = rd_cnt; we0 = we_cnt; err0 = err_cnt; oe0 = oe_clks;
    busy_bits = 0;
    ta_s = 1'b1;
    rdat = '0;

    mdc_bit(1'b1, 1'b0, smp);
    for (int i = 0; i < npre; i++) mdc_bit(1'b1, 1'b1, smp);
    for (int i = 0; i < 32; i++) begin
      mdc_bit(!(reading && i >= 14), fb[31-i], smp);
      if (i == 15) ta_s = smp;
      if (i >= 16) rdat[31-i] = smp;
      if (bus.busy) busy_bits++;
      if (i == abort_bit) begin
        check("oe_before_rst", 32'(bus.mdio_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("oe_after_rst", 32'(bus.mdio_oe), 32'd0);
        check("busy_after_rst", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        m_oe = 1'b0;
        repeat (MDC_CLKS) @(negedge clk);
        return;
      end
    end
    m_oe = 1'b0;

    check("rd_pulses", 32'(rd_cnt - rd0), 32'(exp_rd));
    check("we_pulses", 32'(we_cnt - we0), 32'(exp_we));
    check("err_pulses", 32'(err_cnt - err0), 32'(exp_err));
    check("oe_clks", 32'(oe_clks - oe0), exp_rd ? 32'(17 * MDC_CLKS) : 32'd0);
    check("busy_bits", 32'(busy_bits), 32'(exp_busy));
    check("busy_end", 32'(bus.busy), 32'd0);
    if (exp_rd) begin
      check("rd_addr", 32'(rd_addr), 32'(ra));
      check("ta_bit", 32'(ta_s), 32'd0);
      check("rd_data", 32'(rdat), 32'(host_mem[ra]));
    end
    if (exp_we) begin
      check("we_addr", 32'(we_addr), 32'(ra));
      check("we_data", 32'(we_data), 32'(wd));
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] op;
    logic [4:0] phy;
    bus.mdc = 1'b0;
    for (int i = 0; i < 32; i++) host_mem[i] = 16'($urandom);
    host_mem[2] = 16'h0141;

    repeat (4) @(negedge clk);
    check("rst_oe", 32'(bus.mdio_oe), 32'd0);
    check("rst_out", 32'(bus.mdio_out), 32'd0);
    check("rst_addr", 32'(bus.reg_addr), 32'd0);
    check("rst_strobes", {29'd0, bus.reg_rd, bus.reg_we, bus.frame_err}, 32'd0);
    check("rst_wdata", 32'(bus.reg_wdata), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_frame(32, 2'b01, MY_PHY, 5'h04, 16'hA5C3, -1);
    do_frame(32, 2'b10, MY_PHY, 5'h02, 16'h0000, -1);
    do_frame(32, 2'b10, 5'h03, 5'h02, 16'h0000, -1);
    do_frame(32, 2'b01, 5'h03, 5'h05, 16'h1234, -1);
    do_frame(32, 2'b01, MY_PHY, 5'h05, 16'h5A5A, -1);
    do_frame(31, 2'b01, MY_PHY, 5'h06, 16'hC0DE, -1);
    do_frame(32, 2'b01, MY_PHY, 5'h06, 16'hC0DE, -1);
    do_frame(32, 2'b11, MY_PHY, 5'h07, 16'h0F0F, -1);
    do_frame(32, 2'b00, MY_PHY, 5'h07, 16'hF0F0, -1);
    do_frame(32, 2'b10, MY_PHY, 5'h1F, 16'h0000, 23);
    do_frame(32, 2'b10, MY_PHY, 5'h1F, 16'h0000, -1);
    do_frame(MINP, 2'b10, MY_PHY, 5'h00, 16'h0000, -1);

    for (int n = 0; n < 16; n++) begin
      op  = 2'($urandom_range(0, 3));
      phy = ($urandom_range(0, 2) == 0) ? 5'($urandom) : MY_PHY;
      do_frame($urandom_range(MINP - 2, MINP + 6), op, phy, 5'($urandom), 16'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
